nf10_1g_rx_arbiter: RTL and testbench

- Packet-granular, round-robin arbiter that merges the two 1G receive streams (port 0 and port 1, each already width-converted to the system AXI-Stream width) into one AXI-Stream master toward the datapath.
- Sits between the two master-side width converters of the 1G interface and the downstream input arbiter/output queues.
- Never interleaves beats of different packets.
- Passes tdata/tstrb/tuser/tlast through unchanged.
- Has a single registered output stage.

---
 rtl/nf10_1g_rx_arb_pkg.sv | 24 ++
 rtl/nf10_axis_out_reg.sv | 45 ++++
 rtl/nf10_1g_rx_arbiter.sv | 133 +++++++++++++
 tb/tb_nf10_1g_rx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_1g_rx_arb_pkg.sv
// Shared types and constants for the 1G receive-side packet arbiter.
// Used by nf10_1g_rx_arbiter and nf10_axis_out_reg.
package nf10_1g_rx_arb_pkg;

    localparam int PKT_CNT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

    typedef logic port_idx_t;

    // First valid port after last, wrapping back to last itself.
    function automatic port_idx_t rr_pick(
        input port_idx_t  last,
        input logic [1:0] valid
    );
        port_idx_t nxt;
        nxt = ~last;
        return valid[nxt] ? nxt : last;
    endfunction

endpackage

// File: rtl/nf10_axis_out_reg.sv
// Single registered AXI-Stream output stage with its upstream ready term.
// Holds the beat stable while the downstream stalls.
module nf10_axis_out_reg
    import nf10_1g_rx_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    in_data,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  in_strb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   in_user,
    input  logic                            in_last,
    input  logic                            in_load,
    output logic                            in_ready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast
);

    assign in_ready = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (in_load) begin
            m_axis_tdata  <= in_data;
            m_axis_tstrb  <= in_strb;
            m_axis_tuser  <= in_user;
            m_axis_tlast  <= in_last;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/nf10_1g_rx_arbiter.sv
// Packet-granular round-robin merge of the two 1G receive streams.
// Define NF10_1G_RX_ARB_STATS_EN to build the per-port packet counters.
module nf10_1g_rx_arbiter
    import nf10_1g_rx_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                            s_axis_tvalid_0,
    output logic                            s_axis_tready_0,
    input  logic                            s_axis_tlast_0,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                            s_axis_tvalid_1,
    output logic                            s_axis_tready_1,
    input  logic                            s_axis_tlast_1,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [PKT_CNT_WIDTH-1:0]        pkt_cnt_0,
    output logic [PKT_CNT_WIDTH-1:0]        pkt_cnt_1
);

    arb_state_t state_q, state_d;
    port_idx_t  grant_q, grant_d;
    port_idx_t  last_q, last_d;

    logic [C_AXIS_DATA_WIDTH-1:0]   sel_data;
    logic [C_AXIS_DATA_WIDTH/8-1:0] sel_strb;
    logic [C_AXIS_TUSER_WIDTH-1:0]  sel_user;
    logic                           sel_valid;
    logic                           sel_last;
    logic                           out_ready;
    logic                           tready_g;
    logic                           accept;
    logic                           eop;

    assign sel_data  = grant_q ? s_axis_tdata_1  : s_axis_tdata_0;
    assign sel_strb  = grant_q ? s_axis_tstrb_1  : s_axis_tstrb_0;
    assign sel_user  = grant_q ? s_axis_tuser_1  : s_axis_tuser_0;
    assign sel_valid = grant_q ? s_axis_tvalid_1 : s_axis_tvalid_0;
    assign sel_last  = grant_q ? s_axis_tlast_1  : s_axis_tlast_0;

    assign tready_g = (state_q == PKT) && out_ready;
    assign accept   = tready_g && sel_valid;
    assign eop      = accept && sel_last;

    assign s_axis_tready_0 = tready_g && !grant_q;
    assign s_axis_tready_1 = tready_g && grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Grant is decided in IDLE and frozen until the granted tlast is taken.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid_0 || s_axis_tvalid_1) begin
                    grant_d = rr_pick(last_q,
                                      {s_axis_tvalid_1, s_axis_tvalid_0});
                    last_d  = grant_d;
                    state_d = PKT;
                end
            end
            PKT: begin
                if (eop) state_d = IDLE;
            end
        endcase
    end

    nf10_axis_out_reg #(
        .C_AXIS_DATA_WIDTH  (C_AXIS_DATA_WIDTH),
        .C_AXIS_TUSER_WIDTH (C_AXIS_TUSER_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .in_data       (sel_data),
        .in_strb       (sel_strb),
        .in_user       (sel_user),
        .in_last       (sel_last),
        .in_load       (accept),
        .in_ready      (out_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

`ifdef NF10_1G_RX_ARB_STATS_EN
    logic [PKT_CNT_WIDTH-1:0] cnt_0_q;
    logic [PKT_CNT_WIDTH-1:0] cnt_1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_0_q <= '0;
            cnt_1_q <= '0;
        end else if (eop) begin
            if (grant_q) cnt_1_q <= cnt_1_q + PKT_CNT_WIDTH'(1);
            else         cnt_0_q <= cnt_0_q + PKT_CNT_WIDTH'(1);
        end
    end

    assign pkt_cnt_0 = cnt_0_q;
    assign pkt_cnt_1 = cnt_1_q;
`else
    assign pkt_cnt_0 = '0;
    assign pkt_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_nf10_1g_rx_arbiter.sv
// Directed and random checks of nf10_1g_rx_arbiter against a packet-order model.
// Counter expectations follow NF10_1G_RX_ARB_STATS_EN.
module tb_nf10_1g_rx_arbiter;

    typedef struct {
        logic [63:0]  d;
        logic [7:0]   s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  td [2];
    logic [7:0]   ts [2];
    logic [127:0] tu [2];
    logic         tv [2];
    logic         tl [2];
    logic         tr [2];
    logic [63:0]  m_tdata;
    logic [7:0]   m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic [31:0]  pkt_cnt_0, pkt_cnt_1;

    int total = 0;
    int bad   = 0;

    beat_t       src [2][$];
    int          plen [2][$];
    beat_t       exp_q [$];
    beat_t       got [$];
    int          got_cyc [$];
    logic [1:0]  started;
    int          acc [2];
    int          m_last = 1;
    logic [31:0] m_cnt [2];
    int          pkt_id = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          stall_lo = 0;
    bit          gap_en = 0;
    int          stall_seen = 0;

    always #5 clk = ~clk;

    nf10_1g_rx_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .s_axis_tdata_0  (td[0]),
        .s_axis_tstrb_0  (ts[0]),
        .s_axis_tuser_0  (tu[0]),
        .s_axis_tvalid_0 (tv[0]),
        .s_axis_tready_0 (tr[0]),
        .s_axis_tlast_0  (tl[0]),
        .s_axis_tdata_1  (td[1]),
        .s_axis_tstrb_1  (ts[1]),
        .s_axis_tuser_1  (tu[1]),
        .s_axis_tvalid_1 (tv[1]),
        .s_axis_tready_1 (tr[1]),
        .s_axis_tlast_1  (tl[1]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tstrb    (m_tstrb),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tlast    (m_tlast),
        .pkt_cnt_0       (pkt_cnt_0),
        .pkt_cnt_1       (pkt_cnt_1)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [255:0] pack(input beat_t b);
        return {55'd0, b.u, b.d, b.s, b.l};
    endfunction

    task automatic add_pkt(input int p, input int n, input int base);
        beat_t b;
        pkt_id++;
        for (int i = 0; i < n; i++) begin
            b.d = (base != 0) ? 64'(base * (i + 1)) : {$urandom, $urandom};
            b.s = (base != 0) ? 8'hFF : 8'($urandom);
            b.u = {1'(p), 31'(pkt_id), $urandom, $urandom, $urandom};
            b.l = (i == n - 1);
            src[p].push_back(b);
        end
        plen[p].push_back(n);
        m_cnt[p] = m_cnt[p] + 32'd1;
    endtask

    // Whole packets in round-robin order, starting after the last grant.
    task automatic build_exp();
        beat_t t [2][$];
        int    pl [2][$];
        int    p, n;
        t[0] = src[0];
        t[1] = src[1];
        pl[0] = plen[0];
        pl[1] = plen[1];
        plen[0].delete();
        plen[1].delete();
        exp_q.delete();
        while (pl[0].size() + pl[1].size() > 0) begin
            p = (pl[1 - m_last].size() > 0) ? 1 - m_last : m_last;
            n = pl[p].pop_front();
            repeat (n) exp_q.push_back(t[p].pop_front());
            m_last = p;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int p = 0; p < 2; p++) begin
            if (src[p].size() > 0) begin
                b = src[p][0];
                tv[p] = started[p] ? (!gap_en || $urandom_range(0, 3) != 0)
                                   : 1'b1;
                td[p] = b.d;
                ts[p] = b.s;
                tu[p] = b.u;
                tl[p] = b.l;
            end else begin
                tv[p] = 1'b0;
                td[p] = '0;
                ts[p] = '0;
                tu[p] = '0;
                tl[p] = 1'b0;
            end
        end
        case (rdy_mode)
            1:       m_tready = ($urandom_range(0, 3) != 0);
            2:       m_tready = !(cyc >= stall_lo && cyc < stall_lo + 5);
            default: m_tready = 1'b1;
        endcase
    endtask

    task automatic run(input int max_cyc, input int stop_p, input int stop_n);
        beat_t b, prev;
        bit    prev_stall = 0;
        int    n = 0;
        got.delete();
        got_cyc.delete();
        acc[0] = 0;
        acc[1] = 0;
        stall_seen = 0;
        forever begin
            @(negedge clk);
            drive();
            #1;
            b.d = m_tdata;
            b.s = m_tstrb;
            b.u = m_tuser;
            b.l = m_tlast;
            if (prev_stall) begin
                chk("hold_beat", pack(b), pack(prev));
                chk("hold_valid", m_tvalid, 1'b1);
            end
            if (m_tvalid && !m_tready) begin
                stall_seen++;
                chk("stall_tready", {tr[1], tr[0]}, 2'b00);
            end
            prev_stall = m_tvalid && !m_tready;
            prev = b;
            if (m_tvalid && m_tready) begin
                got.push_back(b);
                got_cyc.push_back(cyc);
            end
            for (int p = 0; p < 2; p++) begin
                if (tv[p] && tr[p]) begin
                    acc[p]++;
                    started[p] = !src[p][0].l;
                    void'(src[p].pop_front());
                end
            end
            cyc++;
            n++;
            if (stop_p >= 0 && acc[stop_p] >= stop_n) break;
            if (src[0].size() + src[1].size() == 0 &&
                got.size() >= exp_q.size()) break;
            if (n >= max_cyc) begin
                chk("timeout", {32'(src[0].size() + src[1].size()),
                                32'(got.size())},
                    {32'd0, 32'(exp_q.size())});
                break;
            end
        end
        @(negedge clk);
        drive();
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk(tag, pack(got[i]), pack(exp_q[i]));
    endtask

    task automatic check_cnt(input string tag);
`ifdef NF10_1G_RX_ARB_STATS_EN
        chk({tag, "_cnt0"}, pkt_cnt_0, m_cnt[0]);
        chk({tag, "_cnt1"}, pkt_cnt_1, m_cnt[1]);
`else
        chk({tag, "_cnt0"}, pkt_cnt_0, 32'd0);
        chk({tag, "_cnt1"}, pkt_cnt_1, 32'd0);
`endif
    endtask

    // Caller is at a negedge; reset covers one rising edge before the checks.
    task automatic do_reset();
        reset = 1'b1;
        src[0].delete();
        src[1].delete();
        plen[0].delete();
        plen[1].delete();
        started = 2'b00;
        rdy_mode = 0;
        gap_en = 0;
        drive();
        @(negedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_data", {m_tuser, m_tdata, m_tstrb}, 200'd0);
        chk("rst_tready", {tr[1], tr[0]}, 2'b00);
        chk("rst_cnt", {pkt_cnt_1, pkt_cnt_0}, 64'd0);
        m_last = 1;
        m_cnt[0] = 32'd0;
        m_cnt[1] = 32'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int start;
        started = 2'b00;
        do_reset();

        // Single 3-beat packet on port 0
        add_pkt(0, 3, 'h11);
        build_exp();
        start = cyc;
        run(100, -1, 0);
        check_beats("single");
        if (got_cyc.size() == 3) begin
            chk("single_lat", got_cyc[0], start + 2);
            chk("single_b2", got_cyc[1], start + 3);
            chk("single_b3", got_cyc[2], start + 4);
        end
        check_cnt("single");

        // Both ports busy from reset: 0,1,0,1
        do_reset();
        for (int k = 0; k < 2; k++) begin
            add_pkt(0, 4, 0);
            add_pkt(1, 4, 0);
        end
        build_exp();
        run(200, -1, 0);
        check_beats("rr");
        check_cnt("rr");

        // Five-cycle downstream stall mid-packet
        add_pkt(0, 8, 0);
        add_pkt(1, 4, 0);
        build_exp();
        rdy_mode = 2;
        stall_lo = cyc + 4;
        run(200, -1, 0);
        rdy_mode = 0;
        check_beats("stall");
        chk("stall_seen", stall_seen, 5);
        check_cnt("stall");

        // Back-to-back single-beat packets
        for (int k = 0; k < 6; k++) begin
            add_pkt(0, 1, 0);
            add_pkt(1, 1, 0);
        end
        build_exp();
        run(200, -1, 0);
        check_beats("onebeat");
        for (int i = 0; i + 1 < got_cyc.size(); i++)
            chk("onebeat_gap", got_cyc[i + 1] - got_cyc[i], 2);
        check_cnt("onebeat");

        // Random packets, random ready, mid-packet valid gaps
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 2; p++)
                repeat ($urandom_range(1, 4))
                    add_pkt(p, $urandom_range(1, 6), 0);
            build_exp();
            rdy_mode = 1;
            gap_en = 1;
            run(2000, -1, 0);
            rdy_mode = 0;
            gap_en = 0;
            check_beats("rand");
            check_cnt("rand");
        end

        // Reset after beat 2 of a 5-beat packet on port 1
        add_pkt(1, 5, 0);
        build_exp();
        run(100, 1, 2);
        do_reset();
        add_pkt(1, 2, 0);
        add_pkt(0, 2, 0);
        build_exp();
        run(100, -1, 0);
        check_beats("post_rst");
        if (got.size() > 0) chk("post_rst_port", got[0].u[127], 1'b0);
        check_cnt("post_rst");

`ifdef NF10_1G_RX_ARB_STATS_EN
        force dut.cnt_1_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_1_q;
        m_cnt[1] = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", pkt_cnt_1, m_cnt[1]);
`endif
        add_pkt(1, 2, 0);
        build_exp();
        run(100, -1, 0);
        check_beats("wrap");
        check_cnt("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
